// File: rtl/fifo_wptr_full.sv
// Write-side control of the async FIFO: write pointer, synchronized read pointer,
// full/almost-full flags, write-side fill level and sticky overflow, all in wclk.
module fifo_wptr_full #(
    parameter int ADDRSIZE  = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic                wclken,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                woverflow
);

    localparam int DEPTH = 2 ** ADDRSIZE;
    localparam logic [ADDRSIZE:0] AF_THRESH = (ADDRSIZE + 1)'(DEPTH - AF_MARGIN);

    logic [ADDRSIZE:0] wbin_q, wbin_d;
    logic [ADDRSIZE:0] wptr_q, wptr_d;
    logic [ADDRSIZE:0] wq1_rptr_q, wq2_rptr_q;
    logic              wfull_q, wfull_d;
    logic              walmost_full_q, walmost_full_d;
    logic [ADDRSIZE:0] wlevel_q, wlevel_d;
    logic              woverflow_q, woverflow_d;

    logic              accept;
    logic [ADDRSIZE:0] rbin;

    // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
    function automatic logic [ADDRSIZE:0] grayToBin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    always_comb begin
        accept         = winc & ~wfull_q;
        wbin_d         = wbin_q + {{ADDRSIZE{1'b0}}, accept};
        wptr_d         = (wbin_d >> 1) ^ wbin_d;
        rbin           = grayToBin(wq2_rptr_q);
        wlevel_d       = wbin_d - rbin;
        walmost_full_d = (wlevel_d >= AF_THRESH);
        wfull_d        = (wptr_d == {~wq2_rptr_q[ADDRSIZE:ADDRSIZE-1],
                                     wq2_rptr_q[ADDRSIZE-2:0]});
        woverflow_d    = woverflow_q | (winc & wfull_q);
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q         <= '0;
            wptr_q         <= '0;
            wq1_rptr_q     <= '0;
            wq2_rptr_q     <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            wlevel_q       <= '0;
            woverflow_q    <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wptr_q         <= wptr_d;
            wq1_rptr_q     <= rptr;
            wq2_rptr_q     <= wq1_rptr_q;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            wlevel_q       <= wlevel_d;
            woverflow_q    <= woverflow_d;
        end
    end

    assign waddr        = wbin_q[ADDRSIZE-1:0];
    assign wclken       = accept;
    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = walmost_full_q;
    assign wlevel       = wlevel_q;
    assign woverflow    = woverflow_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboard bench for fifo_wptr_full: stimulus pushes per-edge expectations from a
// count-based model, a monitor pops and compares after every wclk rising edge.
module tb_fifo_wptr_full;

    logic       wclk = 1'b0;
    logic       wrst = 1'b1;
    logic       winc = 1'b1;
    logic [4:0] rptr = 5'b10101;
    logic [3:0] waddr;
    logic       wclken;
    logic [4:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;
    logic       woverflow;

    fifo_wptr_full #(.ADDRSIZE(4), .AF_MARGIN(2)) dut (
        .wclk        (wclk),
        .wrst        (wrst),
        .winc        (winc),
        .rptr        (rptr),
        .waddr       (waddr),
        .wclken      (wclken),
        .wptr        (wptr),
        .wfull       (wfull),
        .walmost_full(walmost_full),
        .wlevel      (wlevel),
        .woverflow   (woverflow)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic [3:0] waddr;
        logic       wclken;
        logic [4:0] wptr;
        logic       wfull;
        logic       waf;
        logic [4:0] wlevel;
        logic       wovf;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: counts are plain integers; the read count is delayed two edges.
    int mWbin = 0, mRq1 = 0, mRq2 = 0, mLevel = 0;
    bit mFull = 0, mAf = 0, mOvf = 0;
    int hist[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit inc, input int rb);
        exp_t e;
        bit   acc;
        @(negedge wclk);
        wrst = rst;
        winc = inc;
        rptr = 5'((rb ^ (rb >> 1)) % 32);
        if (rst) begin
            mWbin = 0; mRq1 = 0; mRq2 = 0; mLevel = 0;
            mFull = 0; mAf = 0; mOvf = 0;
        end else begin
            acc    = inc && !mFull;
            mOvf   = mOvf || (inc && mFull);
            mWbin  = (mWbin + int'(acc)) % 32;
            mLevel = (mWbin - mRq2 + 32) % 32;
            mFull  = (mLevel == 16);
            mAf    = (mLevel >= 14);
            mRq2   = mRq1;
            mRq1   = rb % 32;
        end
        e.waddr  = 4'(mWbin % 16);
        e.wptr   = 5'(mWbin ^ (mWbin >> 1));
        e.wclken = inc && !mFull;
        e.wfull  = mFull;
        e.waf    = mAf;
        e.wlevel = 5'(mLevel);
        e.wovf   = mOvf;
        expQ.push_back(e);
    endtask

    task automatic afterEdge();
        @(posedge wclk);
        #2;
    endtask

    // Monitor: one expectation per rising edge, compared just after the edge.
    always @(posedge wclk) begin
        exp_t e;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("waddr", 32'(waddr), 32'(e.waddr));
            checkOutput("wclken", 32'(wclken), 32'(e.wclken));
            checkOutput("wptr", 32'(wptr), 32'(e.wptr));
            checkOutput("wfull", 32'(wfull), 32'(e.wfull));
            checkOutput("walmost_full", 32'(walmost_full), 32'(e.waf));
            checkOutput("wlevel", 32'(wlevel), 32'(e.wlevel));
            checkOutput("woverflow", 32'(woverflow), 32'(e.wovf));
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset held with a write request and a nonzero read pointer (Gray 10101 = bin 25).
        applyStimulus(1, 1, 25);
        applyStimulus(1, 1, 25);
        afterEdge();
        checkOutput("reset_wptr", 32'(wptr), 32'h0);
        checkOutput("reset_wlevel", 32'(wlevel), 32'h0);

        // Fill 16 entries with the read side idle.
        for (int i = 0; i < 16; i++) applyStimulus(0, 1, 0);
        afterEdge();
        checkOutput("fill_wptr", 32'(wptr), 32'b11000);
        checkOutput("fill_wlevel", 32'(wlevel), 32'd16);
        checkOutput("fill_waddr", 32'(waddr), 32'd0);

        // Writes attempted while full are rejected and flagged.
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 0);
        afterEdge();
        checkOutput("ovf_sticky", 32'(woverflow), 32'd1);
        checkOutput("ovf_wptr", 32'(wptr), 32'b11000);

        // One read: full clears only on the third edge.
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 1);
        afterEdge();
        checkOutput("full_after_2_edges", 32'(wfull), 32'd1);
        applyStimulus(0, 0, 1);
        afterEdge();
        checkOutput("full_after_3_edges", 32'(wfull), 32'd0);
        checkOutput("level_after_read", 32'(wlevel), 32'd15);
        applyStimulus(0, 1, 1);
        afterEdge();
        checkOutput("refull", 32'(wfull), 32'd1);

        // 40 writes with the read pointer trailing four cycles behind; wraps 31->0.
        applyStimulus(1, 0, 0);
        hist.delete();
        for (int i = 0; i < 40; i++) begin
            hist.push_back(mWbin);
            applyStimulus(0, 1, (hist.size() >= 4) ? hist[hist.size() - 4] : 0);
        end
        afterEdge();
        checkOutput("stream_waddr", 32'(waddr), 32'd8);
        checkOutput("stream_wptr", 32'(wptr), 32'b01100);

        // Reset in the middle of a fill, with a write pending.
        applyStimulus(1, 0, 0);
        for (int i = 0; i < 9; i++) applyStimulus(0, 1, 0);
        applyStimulus(1, 1, 0);
        afterEdge();
        checkOutput("midreset_waddr", 32'(waddr), 32'd0);
        checkOutput("midreset_wlevel", 32'(wlevel), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0);
        afterEdge();
        checkOutput("resume_waddr", 32'(waddr), 32'd3);

        applyStimulus(0, 0, 0);
        for (int i = 0; i < 5 && expQ.size() > 0; i++) @(posedge wclk);
        #3;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain pending=%0d expected=0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
